lut_load_ctrl: RTL and testbench

Sequences host loads into the four 7-bit port-B write interfaces of the BPM I/Q lookup tables (bpm1_i, bpm1_q, bpm2_i, bpm2_q). It accepts a command (LUT select, start address, length) and then a stream of 7-bit data beats. It drives the shared port-B address/data buses plus a one-hot write enable, and keeps a running checksum. An optional readback pass verifies that checksum. It sits between the slow-clock host/register interface and the LUT port-B pins.

---
 rtl/lut_load_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_lut_load_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_load_ctrl.sv
// Host-to-LUT port-B load sequencer: streams beats into one of four BPM I/Q tables and keeps a checksum.
// Optional readback verification of that checksum is built when LUT_VERIFY_EN is defined.
module lut_load_ctrl #(
  parameter int AW     = 15,
  parameter int DW     = 7,
  parameter int RD_LAT = 1,
  parameter int CSW    = 22
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_lut,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [AW-1:0]  cmd_len,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [DW-1:0]  wr_data,
  input  logic           abort,
  output logic [AW-1:0]  lut_addrb,
  output logic [DW-1:0]  lut_dinb,
  output logic [3:0]     lut_web,
  input  logic [DW-1:0]  lut_doutb0,
  input  logic [DW-1:0]  lut_doutb1,
  input  logic [DW-1:0]  lut_doutb2,
  input  logic [DW-1:0]  lut_doutb3,
  output logic           busy,
  output logic           done,
  output logic [1:0]     err,
  output logic [CSW-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_t;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;

  state_t         state_reg;
  logic [1:0]     sel_reg;
  logic [AW-1:0]  cur_addr_reg;
  logic [AW-1:0]  remaining_reg;
  logic [AW-1:0]  lut_addrb_reg;
  logic [DW-1:0]  lut_dinb_reg;
  logic [3:0]     lut_web_reg;
  logic [1:0]     err_reg;
  logic [CSW-1:0] checksum_reg;
  logic [3:0]     sel_onehot;
  logic           active;
  logic           accept;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign sel_onehot[gi] = (sel_reg == 2'(gi));
    end
  endgenerate

  // Handshake/status flags are pure decodes of the registered state.
  assign cmd_ready = (state_reg == IDLE);
  assign wr_ready  = (state_reg == WRITE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign active    = (state_reg == WRITE) || (state_reg == VERIFY) || (state_reg == DRAIN);
  assign accept    = cmd_valid && (state_reg == IDLE);

  assign lut_addrb = lut_addrb_reg;
  assign lut_dinb  = lut_dinb_reg;
  assign lut_web   = lut_web_reg;
  assign err       = err_reg;
  assign checksum  = checksum_reg;

`ifdef LUT_VERIFY_EN
  logic [AW-1:0]  start_addr_reg;
  logic [AW-1:0]  len_reg;
  logic [CSW-1:0] rd_sum_reg;
  logic [RD_LAT:0] rd_pipe_reg;
  logic [DW-1:0]  rd_data;
  logic           rd_issue;

  always_comb begin
    rd_data = lut_doutb0;
    case (sel_reg)
      2'd1:    rd_data = lut_doutb1;
      2'd2:    rd_data = lut_doutb2;
      2'd3:    rd_data = lut_doutb3;
      default: rd_data = lut_doutb0;
    endcase
  end

  assign rd_issue = (state_reg == VERIFY) && !abort;

  // rd_pipe_reg[k] marks a read issued k+1 edges ago; the top stage lines up with valid LUT data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sum_reg  <= '0;
      rd_pipe_reg <= '0;
    end else if (accept) begin
      rd_sum_reg  <= '0;
      rd_pipe_reg <= '0;
    end else if (abort && active) begin
      rd_pipe_reg <= '0;
    end else begin
      rd_pipe_reg <= {rd_pipe_reg[RD_LAT-1:0], rd_issue};
      if (rd_pipe_reg[RD_LAT])
        rd_sum_reg <= rd_sum_reg + CSW'(rd_data);
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{lut_doutb0, lut_doutb1, lut_doutb2, lut_doutb3};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      lut_addrb_reg <= '0;
      lut_dinb_reg  <= '0;
      lut_web_reg   <= '0;
      err_reg       <= ERR_OK;
      checksum_reg  <= '0;
`ifdef LUT_VERIFY_EN
      start_addr_reg <= '0;
      len_reg        <= '0;
`endif
    end else begin
      lut_web_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sel_reg       <= cmd_lut;
            cur_addr_reg  <= cmd_addr;
            remaining_reg <= cmd_len;
            checksum_reg  <= '0;
            err_reg       <= ERR_OK;
`ifdef LUT_VERIFY_EN
            start_addr_reg <= cmd_addr;
            len_reg        <= cmd_len;
`endif
            state_reg     <= WRITE;
          end
        end
        WRITE: begin
          // abort wins over a beat presented in the same cycle
          if (abort) begin
            err_reg   <= ERR_ABORT;
            state_reg <= DONE;
          end else if (wr_valid) begin
            lut_addrb_reg <= cur_addr_reg;
            lut_dinb_reg  <= wr_data;
            lut_web_reg   <= sel_onehot;
            checksum_reg  <= checksum_reg + CSW'(wr_data);
            cur_addr_reg  <= cur_addr_reg + 1'b1;
            if (remaining_reg == '0) begin
`ifdef LUT_VERIFY_EN
              cur_addr_reg  <= start_addr_reg;
              remaining_reg <= len_reg;
              state_reg     <= VERIFY;
`else
              state_reg     <= DONE;
`endif
            end else begin
              remaining_reg <= remaining_reg - 1'b1;
            end
          end
        end
`ifdef LUT_VERIFY_EN
        VERIFY: begin
          if (abort) begin
            err_reg   <= ERR_ABORT;
            state_reg <= DONE;
          end else begin
            lut_addrb_reg <= cur_addr_reg;
            cur_addr_reg  <= cur_addr_reg + 1'b1;
            if (remaining_reg == '0)
              state_reg <= DRAIN;
            else
              remaining_reg <= remaining_reg - 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            err_reg   <= ERR_ABORT;
            state_reg <= DONE;
          end else if (rd_pipe_reg == '0) begin
            err_reg   <= (rd_sum_reg != checksum_reg) ? ERR_CSUM : ERR_OK;
            state_reg <= DONE;
          end
        end
`endif
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Randomised scoreboard bench for lut_load_ctrl with a behavioural four-LUT memory model.
// Define LUT_VERIFY_EN to exercise the readback pass (RD_LAT=2 in that build).
module tb_lut_load_ctrl;
  localparam int AW  = 15;
  localparam int DW  = 7;
  localparam int CSW = 22;
`ifdef LUT_VERIFY_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_lut;
  logic [AW-1:0]  cmd_addr;
  logic [AW-1:0]  cmd_len;
  logic           wr_valid;
  logic           wr_ready;
  logic [DW-1:0]  wr_data;
  logic           abort;
  logic [AW-1:0]  lut_addrb;
  logic [DW-1:0]  lut_dinb;
  logic [3:0]     lut_web;
  logic [DW-1:0]  lut_doutb0, lut_doutb1, lut_doutb2, lut_doutb3;
  logic           busy;
  logic           done;
  logic [1:0]     err;
  logic [CSW-1:0] checksum;

  always #5 clk = ~clk;

  lut_load_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CSW(CSW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lut(cmd_lut),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .abort(abort),
    .lut_addrb(lut_addrb), .lut_dinb(lut_dinb), .lut_web(lut_web),
    .lut_doutb0(lut_doutb0), .lut_doutb1(lut_doutb1),
    .lut_doutb2(lut_doutb2), .lut_doutb3(lut_doutb3),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [3:0]    web;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct packed {
    logic [1:0]     err;
    logic [CSW-1:0] sum;
  } cpl_t;

  wr_t  wq[$];
  cpl_t cq[$];
  bit   mon_en = 1'b0;

  // LUT model: write on web, read-first, RD_LAT cycle read pipeline; LUT1 can be made faulty.
  logic [DW-1:0] mem   [4][DEPTH];
  logic [DW-1:0] rpipe [4][RD_LAT];
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (lut_web[n])
        mem[n][lut_addrb] <= (corrupt_en && n == 1 && lut_addrb == corrupt_addr) ? (lut_dinb ^ 7'h01) : lut_dinb;
      rpipe[n][0] <= mem[n][lut_addrb];
      for (int k = 1; k < RD_LAT; k++) rpipe[n][k] <= rpipe[n][k-1];
    end
  end
  assign lut_doutb0 = rpipe[0][RD_LAT-1];
  assign lut_doutb1 = rpipe[1][RD_LAT-1];
  assign lut_doutb2 = rpipe[2][RD_LAT-1];
  assign lut_doutb3 = rpipe[3][RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes on any web activity and expected completions on done.
  wr_t  m_w;
  cpl_t m_c;
  always @(negedge clk) begin
    if (mon_en) begin
      if (lut_web != 4'b0) begin
        if (wq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_write: web=%b addr=0x%0h data=0x%0h", lut_web, lut_addrb, lut_dinb);
        end else begin
          m_w = wq.pop_front();
          chk("write_web", 32'(lut_web), 32'(m_w.web));
          chk("write_addr", 32'(lut_addrb), 32'(m_w.addr));
          chk("write_data", 32'(lut_dinb), 32'(m_w.data));
          $display("write web=%b addr=0x%04h data=0x%02h", lut_web, lut_addrb, lut_dinb);
        end
      end
      if (done) begin
        if (cq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: err=%0d checksum=0x%0h", err, checksum);
        end else begin
          m_c = cq.pop_front();
          chk("done_err", 32'(err), 32'(m_c.err));
          chk("done_checksum", 32'(checksum), 32'(m_c.sum));
          chk("writes_outstanding", 32'(wq.size()), 32'd0);
          $display("done err=%0d checksum=0x%06h", err, checksum);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL idle_timeout: cmd_ready stayed 0");
    end
  endtask

  // mode: 0 random data, 1 all 0x7F, 2 pattern 0x11*(i+1). abort_at < 0 means no abort.
  task automatic load(input int lut, input int addr, input int len, input int gap_pct,
                      input int abort_at, input int mode, input int exp_err);
    logic [DW-1:0] d[$];
    logic [CSW-1:0] sum = '0;
    int nb;
    int t;
    cpl_t c;
    nb = (abort_at >= 0 && abort_at <= len) ? abort_at : len + 1;
    for (int i = 0; i <= len; i++) begin
      case (mode)
        1:       d.push_back(7'h7F);
        2:       d.push_back(DW'(8'h11 * (i + 1)));
        default: d.push_back(DW'($urandom));
      endcase
    end
    for (int i = 0; i < nb; i++) sum += CSW'(d[i]);
    c.err = (nb <= len) ? 2'd2 : 2'(exp_err);
    c.sum = sum;
    wait_idle();
    cq.push_back(c);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_lut = 2'(lut); cmd_addr = AW'(addr); cmd_len = AW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        wr_valid = 1'b0;
        chk("cmd_ready_in_write", 32'(cmd_ready), 32'd0);
        @(negedge clk);
      end
      chk("wr_ready_in_write", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = d[i];
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      wq.push_back('{web: 4'(1 << lut), addr: AW'(addr + i), data: d[i]});
      @(negedge clk);
    end
    wr_valid = 1'b0;
    t = 0;
    while (cq.size() != 0 && t < 40000) begin @(negedge clk); t++; end
    if (cq.size() != 0) begin
      checks++; fails++;
      $display("FAIL done_timeout: no done after %0d cycles", t);
      cq.delete(); wq.delete();
    end
    @(negedge clk);
    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    $display("load lut=%0d addr=0x%04h len=%0d abort_at=%0d err=%0d checksum=0x%06h",
             lut, addr, len, abort_at, err, checksum);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    chk({tag, "_web"}, 32'(lut_web), 32'd0);
    chk({tag, "_addrb"}, 32'(lut_addrb), 32'd0);
    chk({tag, "_dinb"}, 32'(lut_dinb), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_lut = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    load(2, 'h0100, 2, 0, -1, 2, 0);
    chk("tp_checksum_66", 32'(checksum), 32'h66);
    load(0, 'h7FFE, 3, 0, -1, 0, 0);
    load(1, int'($urandom_range(DEPTH-1)), 5, 50, -1, 0, 0);
    load(3, 'h0200, 3, 0, 1, 0, 0);
    chk("abort_err_sticky", 32'(err), 32'd2);

    // abort in IDLE must be ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);

    for (int r = 0; r < 8; r++) begin
      int ab;
      int ln;
      ln = int'($urandom_range(24));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(ln)) : -1;
      load(int'($urandom_range(3)), int'($urandom_range(DEPTH-1)), ln,
           int'($urandom_range(60)), ab, 0, 0);
    end

`ifdef LUT_VERIFY_EN
    corrupt_en = 1'b1; corrupt_addr = 'h0345;
    load(1, 'h0340, 15, 20, -1, 0, 1);
    chk("verify_bad_err", 32'(err), 32'd1);
    corrupt_en = 1'b0;
    load(1, 'h0340, 15, 20, -1, 0, 0);
    chk("verify_clean_err", 32'(err), 32'd0);
`endif

    load(0, 0, DEPTH - 1, 0, -1, 1, 0);
    chk("full_table_checksum", 32'(checksum), 32'h3F8000);

    // reset in the middle of a load
    wait_idle();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_lut = 2'd3; cmd_addr = 'h1234; cmd_len = 'd99;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = DW'($urandom);
      wq.push_back('{web: 4'b1000, addr: AW'('h1234 + i), data: wr_data});
      @(negedge clk);
    end
    wr_data = DW'($urandom);
    rst = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk_reset_outputs("midload_reset");
    chk("midload_writes_outstanding", 32'(wq.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
